hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The hazard_unit SHALL expose these ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- ra_addr_id  in  regaddr_t(5)  ID source A.
- rb_addr_id  in  regaddr_t(5)  ID source B.
- rd_addr_id  in  regaddr_t(5)  ID destination; 0 = no write.
- id_lat  in  3  cycles until the ID instruction's result is forwardable; 0 = single-cycle, covered by forwarding.
- branch_taken_ex  in  1  taken branch resolved in EX.
- stall_if  out  1  hold PC and IF/ID.
- stall_id  out  1  hold ID.
- bubble_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.
- busy_mask  out  32  bit n set = r n pending.

Function
REQ-002 The hazard_unit SHALL hold one 3-bit unsigned countdown per register r1..r31; r0 SHALL never be tracked, and busy_mask[0] SHALL be 0 always.
REQ-003 busy_mask[n] SHALL be 1 iff counter[n] != 0.
REQ-004 raw_hazard SHALL be 1 when id_valid=1 and either source is nonzero with a nonzero counter.
REQ-005 waw_hazard SHALL be 1 when id_valid=1, rd_addr_id != 0 and counter[rd_addr_id] != 0.
REQ-006 stall SHALL be (raw_hazard | waw_hazard) & !branch_taken_ex.
REQ-007 stall_if, stall_id and bubble_ex SHALL each equal stall, combinationally in the same cycle.
REQ-008 flush_if_id and flush_id_ex SHALL equal branch_taken_ex, combinationally; the branch SHALL have priority over any stall.
REQ-009 An instruction issues when id_valid=1, stall=0 and branch_taken_ex=0.
REQ-010 On issue with rd_addr_id != 0 and id_lat != 0, counter[rd_addr_id] SHALL load id_lat at the next edge.
REQ-011 Every other nonzero counter SHALL decrement by 1 per cycle, saturating at 0 with no wrap below 0.
REQ-012 A counter loaded on an edge SHALL NOT also decrement on that edge.
REQ-013 Issue with id_lat=0 or rd_addr_id=0 SHALL change no counter.
REQ-014 A squashed ID instruction (branch_taken_ex=1) SHALL change no counter.
REQ-015 Counters of older in-flight instructions SHALL keep decrementing through a flush.
REQ-016 With an issue at edge T and latency L: a dependent in ID SHALL stall in cycles T+1..T+L and issue in cycle T+L+1.
REQ-017 id_valid=0 SHALL force stall=0 and issue nothing; counters SHALL still decrement.
REQ-018 No counter SHALL ever be loaded while nonzero; waw_hazard guarantees this.
REQ-019 Multiple counters SHALL decrement concurrently and independently.

Reset
REQ-020 While rst=1, every counter SHALL clear to 0 at the edge.
REQ-021 While rst=1, all outputs SHALL be driven 0 regardless of other inputs, including branch_taken_ex.
REQ-022 Reset asserted mid-countdown SHALL discard all pending state; the first cycle after rst falls SHALL see busy_mask=0 and no stall.

Verification
REQ-023 Scenario: issue rd=5, lat=2 at T; ID ra=5 at T+1 -> stall=1 at T+1 and T+2; stall=0 at T+3; busy_mask[5] = 1,1,0 at T+1..T+3.
REQ-024 Scenario: rd=0 with lat=3 issued, then ra=0 -> busy_mask=0 throughout and no stall ever.
REQ-025 Scenario: counter[7]=2 pending; ID rd=7, lat=1, sources unrelated -> WAW stall for 2 cycles; issue on cycle 3; counter[7]=1 next cycle.
REQ-026 Scenario: ID ra=9 with counter[9]=3 and branch_taken_ex=1 -> stall=0 and both flushes=1 that cycle; counter[9]=2 next cycle; ID instruction leaves no state.
REQ-027 Scenario: issue rd=3 lat=4, then rd=4 lat=1 the next cycle -> counters 4/0, then 3/1, then 2/0; busy_mask bits 3,4 track independently.
REQ-028 Scenario: counter[12]=5; rst=1 for one cycle with id_valid=1 and branch_taken_ex=1 -> all outputs 0 during reset; busy_mask=0 after.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-style hazard detection for an in-order pipeline.
// Each architectural register r1..r31 has a 3-bit countdown that holds the
// number of cycles until the result of its in-flight writer can be forwarded.
// A nonzero countdown on a source (RAW) or destination (WAW) of the ID
// instruction stalls the front end. A taken branch in EX squashes IF/ID and
// ID/EX, and it takes priority over any stall.
module hazard_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  ra_addr_id,
   input  logic [4:0]  rb_addr_id,
   input  logic [4:0]  rd_addr_id,
   input  logic [2:0]  id_lat,
   input  logic        branch_taken_ex,
   output logic        stall_if,
   output logic        stall_id,
   output logic        bubble_ex,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] busy_mask
);

   // Returns the count reduced by one, holding at zero.
   function automatic logic [2:0] sat_dec(input logic [2:0] cnt);
      if (cnt != 3'd0) begin
         sat_dec = cnt - 3'd1;
      end else begin
         sat_dec = 3'd0;
      end
   endfunction

   logic [31:0][2:0] cnt_q;
   logic [31:0][2:0] cnt_d;
   logic [31:0]      busy_s;
   logic             raw_s;
   logic             waw_s;
   logic             stall_s;
   logic             issue_s;
   logic             load_s;

   // Pending-register view: r0 is never tracked, so its bit is tied low.
   always_comb begin
      busy_s = 32'd0;
      for (int n = 1; n < 32; n++) begin
         busy_s[n] = (cnt_q[n] != 3'd0);
      end
   end

   // RAW and WAW detection against the pending-register view.
   always_comb begin
      raw_s = 1'b0;
      waw_s = 1'b0;
      if (id_valid) begin
         raw_s = ((ra_addr_id != 5'd0) && busy_s[ra_addr_id]) ||
                 ((rb_addr_id != 5'd0) && busy_s[rb_addr_id]);
         waw_s = (rd_addr_id != 5'd0) && busy_s[rd_addr_id];
      end else begin
         raw_s = 1'b0;
         waw_s = 1'b0;
      end
   end

   // A taken branch overrides the stall. Only an unstalled, unsquashed
   // instruction with a real destination and a nonzero latency loads a counter.
   always_comb begin
      stall_s = (raw_s | waw_s) & ~branch_taken_ex;
      issue_s = id_valid & ~stall_s & ~branch_taken_ex;
      load_s  = issue_s & (rd_addr_id != 5'd0) & (id_lat != 3'd0);
   end

   // Output drive. Reset forces every output low, including the flushes.
   always_comb begin
      if (rst) begin
         stall_if    = 1'b0;
         stall_id    = 1'b0;
         bubble_ex   = 1'b0;
         flush_if_id = 1'b0;
         flush_id_ex = 1'b0;
         busy_mask   = 32'd0;
      end else begin
         stall_if    = stall_s;
         stall_id    = stall_s;
         bubble_ex   = stall_s;
         flush_if_id = branch_taken_ex;
         flush_id_ex = branch_taken_ex;
         busy_mask   = busy_s;
      end
   end

   // Counter next state. A counter that loads on an edge does not also
   // decrement on that edge. All other counters count down independently.
   // WAW stalls guarantee that a load never targets a nonzero counter.
   always_comb begin
      cnt_d = cnt_q;
      for (int n = 1; n < 32; n++) begin
         if (load_s && (rd_addr_id == 5'(n))) begin
            cnt_d[n] = id_lat;
         end else begin
            cnt_d[n] = sat_dec(cnt_q[n]);
         end
      end
      cnt_d[0] = 3'd0;
   end

   // Countdown state with synchronous reset that discards all pending work.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {32{3'd0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit against hand-computed values.
module tb_hazard_unit;

   logic        clk;
   logic        rst;
   logic        id_valid;
   logic [4:0]  ra_addr_id;
   logic [4:0]  rb_addr_id;
   logic [4:0]  rd_addr_id;
   logic [2:0]  id_lat;
   logic        branch_taken_ex;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] busy_mask;

   int checks = 0;
   int errors = 0;

   hazard_unit dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .ra_addr_id      (ra_addr_id),
      .rb_addr_id      (rb_addr_id),
      .rd_addr_id      (rd_addr_id),
      .id_lat          (id_lat),
      .branch_taken_ex (branch_taken_ex),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .bubble_ex       (bubble_ex),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex),
      .busy_mask       (busy_mask)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Order: {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex}
   localparam logic [4:0] O_NONE  = 5'b00000;
   localparam logic [4:0] O_STALL = 5'b11100;
   localparam logic [4:0] O_FLUSH = 5'b00011;

   task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rd, input logic [2:0] lat, input logic br);
      id_valid        = v;
      ra_addr_id      = ra;
      rb_addr_id      = rb;
      rd_addr_id      = rd;
      id_lat          = lat;
      branch_taken_ex = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [4:0] exp_o, input logic [31:0] exp_busy);
      logic [4:0] obs_o;
      obs_o = {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex};
      checks++;
      assert (obs_o === exp_o) else begin
         errors++;
         $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_o, exp_o);
      end
      checks++;
      assert (busy_mask === exp_busy) else begin
         errors++;
         $error("FAIL %s busy_mask observed=%h expected=%h", tag, busy_mask, exp_busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 5'd1, 5'd2, 5'd3, 3'd2, 1'b1);
      tick();
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd3, 3'd2, 1'b1);
      check("reset_outputs", O_NONE, 32'h0);
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
      check("idle_after_reset", O_NONE, 32'h0);

      // RAW: issue rd=5 lat=2, dependent in ID stalls two cycles.
      drive(1'b1, 5'd0, 5'd0, 5'd5, 3'd2, 1'b0);
      check("raw_issue", O_NONE, 32'h0);
      tick();
      drive(1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0);
      check("raw_t1", O_STALL, 32'h0000_0020);
      tick();
      check("raw_t2", O_STALL, 32'h0000_0020);
      tick();
      check("raw_t3", O_NONE, 32'h0);
      tick();

      // r0 destination and source never tracked.
      drive(1'b1, 5'd0, 5'd0, 5'd0, 3'd3, 1'b0);
      check("r0_issue", O_NONE, 32'h0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
      check("r0_read", O_NONE, 32'h0);
      tick();
      check("r0_after", O_NONE, 32'h0);

      // WAW: counter[7]=2, then rd=7 lat=1 with unrelated sources.
      drive(1'b1, 5'd1, 5'd2, 5'd7, 3'd2, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd7, 3'd1, 1'b0);
      check("waw_c1", O_STALL, 32'h0000_0080);
      tick();
      check("waw_c2", O_STALL, 32'h0000_0080);
      tick();
      check("waw_issue", O_NONE, 32'h0);
      tick();
      drive(1'b0, 5'd7, 5'd7, 5'd7, 3'd0, 1'b0);
      check("waw_reload_novalid", O_NONE, 32'h0000_0080);
      tick();
      check("waw_drain", O_NONE, 32'h0);

      // Branch squash: counter[9]=3, dependent in ID with a taken branch.
      drive(1'b1, 5'd0, 5'd0, 5'd9, 3'd3, 1'b0);
      tick();
      drive(1'b1, 5'd9, 5'd0, 5'd10, 3'd4, 1'b1);
      check("br_flush", O_FLUSH, 32'h0000_0200);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
      check("br_after1", O_NONE, 32'h0000_0200);
      tick();
      check("br_after2", O_NONE, 32'h0000_0200);
      tick();
      check("br_after3", O_NONE, 32'h0);

      // Concurrent countdowns: rd=3 lat=4, then rd=4 lat=1.
      drive(1'b1, 5'd0, 5'd0, 5'd3, 3'd4, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd4, 3'd1, 1'b0);
      check("multi_4_0", O_NONE, 32'h0000_0008);
      tick();
      drive(1'b1, 5'd0, 5'd4, 5'd0, 3'd0, 1'b0);
      check("multi_3_1_rb", O_STALL, 32'h0000_0018);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
      check("multi_2_0", O_NONE, 32'h0000_0008);
      tick();
      check("multi_1_0", O_NONE, 32'h0000_0008);
      tick();
      check("multi_0_0", O_NONE, 32'h0);

      // Reset mid-countdown: counter[12]=5, one reset cycle with branch.
      drive(1'b1, 5'd0, 5'd0, 5'd12, 3'd5, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b1, 5'd12, 5'd0, 5'd0, 3'd0, 1'b1);
      check("rst_mid", O_NONE, 32'h0);
      tick();
      rst = 1'b0;
      drive(1'b1, 5'd12, 5'd0, 5'd0, 3'd0, 1'b0);
      check("rst_after", O_NONE, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
